// File: rtl/cpu_defs.sv
// Shared CPU definitions: writeback op codes, stage states and byte-enable constants.
package cpu_defs;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ALU  = 4'd1,
    OP_LB   = 4'd2,
    OP_LBU  = 4'd3,
    OP_LH   = 4'd4,
    OP_LHU  = 4'd5,
    OP_LW   = 4'd6,
    OP_LWL  = 4'd7,
    OP_LWR  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // True for every op that must wait for a data-SRAM response.
  function automatic logic is_load(op_e op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts, aligns and extends load data from a raw little-endian word,
// and produces the per-byte register-file enables for partial-word merges.
module load_align
  import cpu_defs::*;
(
  input  op_e         op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  // addr_lo[0] is ignored for halfwords; misaligned accesses never reach here.
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Select aligned data and byte enables by op and address offset.
  always_comb begin
    data_o = rdata_i;
    be_o   = BE_ALL;
    case (op_i)
      OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: data_o = {24'b0, byte_sel};
      OP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: data_o = {16'b0, half_sel};
      OP_LWL: begin
        unique case (addr_lo_i)
          2'd0: begin data_o = {rdata_i[7:0], 24'b0};  be_o = 4'b1000; end
          2'd1: begin data_o = {rdata_i[15:0], 16'b0}; be_o = 4'b1100; end
          2'd2: begin data_o = {rdata_i[23:0], 8'b0};  be_o = 4'b1110; end
          default: begin data_o = rdata_i;             be_o = BE_ALL;  end
        endcase
      end
      OP_LWR: begin
        unique case (addr_lo_i)
          2'd1: begin data_o = {8'b0, rdata_i[31:8]};   be_o = 4'b0111; end
          2'd2: begin data_o = {16'b0, rdata_i[31:16]}; be_o = 4'b0011; end
          2'd3: begin data_o = {24'b0, rdata_i[31:24]}; be_o = 4'b0001; end
          default: begin data_o = rdata_i;              be_o = BE_ALL;  end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_load_align.sv
// Writeback stage: accepts one retiring instruction, waits for load data when
// needed, and drives the byte-enabled register-file write port and forwarding view.
module wb_load_align
  import cpu_defs::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [3:0]      in_op,
  input  logic [4:0]      in_dest,
  input  logic [31:0]     in_alu_res,
  input  logic [1:0]      in_addr_lo,
  input  logic            mem_data_ok,
  input  logic [31:0]     mem_rdata,
  output logic [3:0]      reg_we,
  output logic [4:0]      WR,
  output logic [31:0]     WD,
  output logic [PC_W-1:0] commit_pc,
  output logic            fwd_valid,
  output logic [4:0]      fwd_dest,
  output logic            fwd_data_ok,
  output logic [31:0]     fwd_data
);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [4:0]      dest_q, dest_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      be_q, be_d;

  op_e         in_op_n;
  logic        hs;
  logic        writes;
  logic [31:0] align_data;
  logic [3:0]  align_be;

  // Unknown op codes retire as NONE.
  assign in_op_n = (in_op <= 4'd8) ? op_e'(in_op) : OP_NONE;

  load_align u_load_align (
    .op_i      (op_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (mem_rdata),
    .data_o    (align_data),
    .be_o      (align_be)
  );

  // Next-state logic: capture on handshake, wait for load data, single-cycle commit.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    addr_lo_d = addr_lo_q;
    pc_d      = pc_q;
    data_d    = data_q;
    be_d      = be_q;
    in_ready  = (state_q == S_IDLE) || (state_q == S_COMMIT);
    hs        = in_valid && in_ready;
    case (state_q)
      S_IDLE, S_COMMIT: begin
        if (hs) begin
          op_d      = in_op_n;
          dest_d    = in_dest;
          addr_lo_d = in_addr_lo;
          pc_d      = in_pc;
          if (is_load(in_op_n)) begin
            state_d = S_WAIT_MEM;
          end else begin
            data_d  = in_alu_res;
            be_d    = BE_ALL;
            state_d = S_COMMIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (mem_data_ok) begin
          data_d  = align_data;
          be_d    = align_be;
          state_d = S_COMMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and held-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      dest_q    <= '0;
      addr_lo_q <= '0;
      pc_q      <= '0;
      data_q    <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      addr_lo_q <= addr_lo_d;
      pc_q      <= pc_d;
      data_q    <= data_d;
      be_q      <= be_d;
    end
  end

  // Outputs come straight from held registers; no input-to-output paths.
  always_comb begin
    writes      = (op_q != OP_NONE) && (dest_q != 5'd0);
    reg_we      = (state_q == S_COMMIT && writes) ? be_q : 4'b0000;
    WR          = dest_q;
    WD          = data_q;
    commit_pc   = pc_q;
    fwd_valid   = (state_q == S_WAIT_MEM || state_q == S_COMMIT) && writes;
    fwd_dest    = dest_q;
    fwd_data_ok = (state_q == S_COMMIT);
    fwd_data    = data_q;
  end

endmodule

// File: doc/wb_load_align.md
Name: wb_load_align

Overview:
- Writeback stage of the 5-stage MIPS pipeline. Produces the byte-enabled write port of the register file: reg_we[3:0], WR, WD.
- Accepts one retiring instruction at a time from the MEM stage. For loads, waits for the data-SRAM response.
- Extracts, aligns and sign/zero-extends load data, including LWL/LWR partial-word merges via byte enables.
- Exposes a forwarding/hazard view of the in-flight destination to the decode stage.

Parameters:
- PC_W, 32, width of the debug PC carried to commit.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  PC_W  instruction PC.
- in_op  in  4  0=NONE, 1=ALU, 2=LB, 3=LBU, 4=LH, 5=LHU, 6=LW, 7=LWL, 8=LWR; other codes are treated as NONE.
- in_dest  in  5  destination register number.
- in_alu_res  in  32  result for ALU op.
- in_addr_lo  in  2  effective address bits [1:0] for loads.
- mem_data_ok  in  1  data-SRAM read response valid, one-cycle pulse.
- mem_rdata  in  32  raw little-endian word, valid with mem_data_ok.
- reg_we  out  4  per-byte write enable to the register file.
- WR  out  5  write register number.
- WD  out  32  write data, pre-positioned in byte lanes.
- commit_pc  out  PC_W  PC of the committing instruction.
- fwd_valid  out  1  an instruction with dest!=0 and op!=NONE is held in the stage.
- fwd_dest  out  5  its destination.
- fwd_data_ok  out  1  fwd_data is final; high only in COMMIT.
- fwd_data  out  32  value as written (equals WD).

Behaviour:
- States: IDLE, WAIT_MEM, COMMIT. Registers: op, dest, addr_lo, pc, data, state.
- Reset (async, rst_n low): state=IDLE; all held registers 0; reg_we=0, WR=0, WD=0, commit_pc=0, fwd_*=0.
- in_ready = (state==IDLE) || (state==COMMIT). Handshake fires when in_valid && in_ready.
- On handshake with a non-load op (NONE/ALU): data<=in_alu_res; next state COMMIT. Latency: commit in the cycle after acceptance.
- On handshake with a load op: next state WAIT_MEM.
- WAIT_MEM: hold until mem_data_ok. On mem_data_ok, data<=aligned(mem_rdata) and move to COMMIT; the register write appears in the following cycle.
- mem_data_ok is sampled only in WAIT_MEM. Pulses in any other state are ignored.
- COMMIT lasts exactly one cycle. On handshake it follows the rules above; otherwise it returns to IDLE. Back-to-back ALU ops therefore commit every cycle.
- reg_we is nonzero only in COMMIT, and only when op!=NONE and dest!=0. It is 0 in every other case.
- WR=dest, WD=data, commit_pc=pc, all driven from registers with no combinational path from inputs.
- Alignment (a=addr_lo, r=mem_rdata):
  - LB/LBU: r[8a+7:8a], sign- or zero-extended; we=1111.
  - LH/LHU: a[1]? r[31:16] : r[15:0], extended; a[0] ignored (misalignment is trapped upstream); we=1111.
  - LW: r; we=1111; a ignored.
  - ALU: we=1111.
  - LWL, a=0: {r[7:0],24'b0}, we=1000.
  - LWL, a=1: {r[15:0],16'b0}, we=1100.
  - LWL, a=2: {r[23:0],8'b0}, we=1110.
  - LWL, a=3: r, we=1111.
  - LWR, a=0: r, we=1111.
  - LWR, a=1: {8'b0,r[31:8]}, we=0111.
  - LWR, a=2: {16'b0,r[31:16]}, we=0011.
  - LWR, a=3: {24'b0,r[31:24]}, we=0001.
- Byte enables are computed from the held op/addr_lo and registered alongside data.
- fwd_valid is high in WAIT_MEM and COMMIT when the held op!=NONE and dest!=0. fwd_data_ok is high in COMMIT only; decode must stall while fwd_valid && !fwd_data_ok on a matching source register.
- Reset mid-WAIT_MEM: the load is dropped with no write. A late mem_data_ok after reset is ignored because state is IDLE.

Decomposition:
- Shared package `cpu_defs` holds:
  - op encodings OP_NONE..OP_LWR (4-bit);
  - state encodings S_IDLE, S_WAIT_MEM, S_COMMIT;
  - the full-word enable constant BE_ALL=4'b1111.
- One natural combinational sub-module, `load_align`: inputs (op, addr_lo, rdata); outputs (data[31:0], be[3:0]). It is shared with the future store-side checker.

Test Plan:
- ALU op, dest=5, res=0x12345678, in_valid one cycle -> next cycle reg_we=1111, WR=5, WD=0x12345678; following cycle reg_we=0.
- LB dest=3, a=2; mem_data_ok two cycles later with r=0x00800000 -> WD=0xFFFFFF80, we=1111. The same stimulus with LBU -> WD=0x00000080.
- LWL a=1, r=0xAABBCCDD -> WD=0xCCDD0000, we=1100. LWR a=2 with the same r -> WD=0x0000AABB, we=0011.
- ALU ops on three consecutive cycles with dest=1,2,3 -> commits on three consecutive cycles with in_ready held high. An ALU op with dest=0 -> reg_we stays 0.
- A load accepted, then a second in_valid during WAIT_MEM -> in_ready=0 until the load reaches COMMIT. fwd_valid=1 with fwd_data_ok=0 in WAIT_MEM; fwd_data_ok=1 in COMMIT.
- rst_n pulsed low in WAIT_MEM, then mem_data_ok arrives -> no write occurs, state is IDLE, all outputs are 0.
